seg_capture: RTL and testbench
==============================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required before a digit is accepted.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 segs  input  7  observed segment bus, active-low (0 = lit); bit6 = a … bit0 = g.
REQ-005 anodes  input  4  observed digit enables, active-low; anodes[n] low selects digit n; digit 3 is the most significant.
REQ-006 digit_en  input  4  mask of the digits that make up a frame; 4'b0001 selects a single-digit display.
REQ-007 digits  output  16  live decoded nibbles; digit n is at [4n+3:4n].
REQ-008 digit_valid  output  4  per-digit flag, set when the digit is captured in the current frame.
REQ-009 frame  output  16  snapshot of digits taken at frame completion.
REQ-010 frame_valid  output  1  one-cycle pulse when frame updates.
REQ-011 decode_err  output  1  one-cycle pulse when a stable pattern is not a legal glyph.

Function
REQ-012 The block shall accept these glyph codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-013 The block shall treat segs=1111111 as blank and every other code as illegal.
REQ-014 The block shall register segs and anodes once, then compare each registered {anodes,segs} pair against the previous sample.
REQ-015 The block shall use three states: IDLE, SETTLE and HELD.
REQ-016 In IDLE, when anodes is one-hot-low, the block shall load the stability counter with 1 and enter SETTLE.
REQ-017 In IDLE, when anodes is not one-hot-low (1111, 0000 or two or more low), the block shall remain in IDLE with no capture and no error.
REQ-018 In SETTLE, when the pair is unchanged, the counter shall increment.
REQ-019 In SETTLE, when the counter reaches STABLE_CYCLES, the block shall accept the pair and enter HELD.
REQ-020 In SETTLE, when the pair changes, the block shall reload the counter with 1 if anodes is still one-hot-low, otherwise enter IDLE.
REQ-021 In HELD, the block shall hold with no further action until the pair changes, then follow the SETTLE change rule.
REQ-022 Accepting a legal glyph on digit n shall write digits[n] and set digit_valid[n] on the acceptance edge.
REQ-023 Acceptance latency shall be STABLE_CYCLES+1 clocks from the first cycle the pair appears at the inputs.
REQ-024 Accepting a blank on digit n shall clear digit_valid[n] and leave digits[n] unchanged.
REQ-025 Accepting an illegal code shall pulse decode_err for one cycle and leave digits and digit_valid unchanged.
REQ-026 Frame completion shall occur on the edge where (digit_valid_next & digit_en) == digit_en and digit_en != 0.
REQ-027 At frame completion the block shall copy digits_next into frame, pulse frame_valid and clear all digit_valid bits.
REQ-028 A capture that completes a frame on an edge shall be included in that frame's snapshot.
REQ-029 digit_en shall be evaluated every cycle; digit_en=0000 shall never complete a frame.
REQ-030 A digit re-captured before frame completion shall overwrite its nibble; the last value wins.

Reset
REQ-031 While reset_n is low at an edge, digits, digit_valid, frame, frame_valid, decode_err, the stability counter and the input registers shall clear to 0, with the input sample registers cleared to anodes=1111, segs=1111111.
REQ-032 The state machine shall return to IDLE on reset.
REQ-033 Reset asserted mid-SETTLE shall discard the partial count; after release a full STABLE_CYCLES window shall be required.

Structure
REQ-034 The shared package seg_pkg shall hold the 16 glyph constants, the BLANK constant, the state encoding and the STABLE_CYCLES default.
REQ-035 A combinational sub-module seg_glyph_decode shall map segs to {legal, blank, nibble[3:0]}; seg_capture shall instantiate it once.

Verification
REQ-036 With digit_en=0001, drive anodes=1110, segs=0001000 held for 6 cycles -> digits[3:0]=A, frame=0x000A, and one frame_valid pulse 5 clocks after the first presentation.
REQ-037 Scan digits 3..0 with glyphs 1,2,3,4, each held 8 cycles, with digit_en=1111 -> frame=0x1234 and exactly one frame_valid pulse on the digit-0 capture edge.
REQ-038 Hold anodes=1101 with segs toggling every 3 cycles -> no capture, digit_valid=0000.
REQ-039 Hold segs=1111110 on digit 2 for 10 cycles -> a single decode_err pulse, digits unchanged, no frame_valid.
REQ-040 Assert reset_n=0 for one cycle during SETTLE, then continue the same stable pair -> capture occurs exactly STABLE_CYCLES+1 clocks after release; all outputs are 0 during reset.
REQ-041 Drive anodes=0000 and anodes=1100 for 20 cycles each -> the block stays in IDLE with no pulses.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment capture block: glyph codes,
// blank pattern, FSM state encoding and anode helpers.
package seg_pkg;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

    // Active-low segment codes, bit6 = a ... bit0 = g
    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0001100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;
    localparam logic [6:0] BLANK   = 7'b1111111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    function automatic logic an_onehot_low(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational map from an active-low segment pattern to a hex nibble,
// flagging legal glyphs and the blank pattern separately.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] segs,
    output logic       legal,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b1;
        blank  = 1'b0;
        nibble = '0;
        case (segs)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// Observes a multiplexed seven-segment display, debounces each {anodes,segs}
// pair, decodes accepted digits and snapshots complete frames.
module seg_capture
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  segs,
    input  logic [3:0]  anodes,
    input  logic [3:0]  digit_en,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [15:0] frame,
    output logic        frame_valid,
    output logic        decode_err
);

    logic [6:0]  seg_q, seg_d, seg_prev_q, seg_prev_d;
    logic [3:0]  an_q, an_d, an_prev_q, an_prev_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] digits_q, digits_d, frame_q, frame_d;
    logic [3:0]  digit_valid_q, digit_valid_d, valid_next;
    logic        frame_valid_q, frame_valid_d, decode_err_q, decode_err_d;
    logic        changed, accept, g_legal, g_blank;
    logic [3:0]  g_nibble;
    logic [1:0]  idx;

    seg_glyph_decode u_decode (
        .segs   (seg_q),
        .legal  (g_legal),
        .blank  (g_blank),
        .nibble (g_nibble)
    );

    always_comb begin
        seg_d      = segs;
        an_d       = anodes;
        seg_prev_d = seg_q;
        an_prev_d  = an_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        changed    = {an_q, seg_q} != {an_prev_q, seg_prev_q};
        idx        = an_index(an_q);

        case (state_q)
            ST_IDLE: begin
                if (an_onehot_low(an_q)) begin
                    cnt_d   = 8'd1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE, ST_HELD: begin
                // A change restarts the window in both states; HELD never counts
                if (changed) begin
                    if (an_onehot_low(an_q)) begin
                        cnt_d   = 8'd1;
                        state_d = ST_SETTLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else if (state_q == ST_SETTLE) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == STABLE_CYCLES[7:0]) begin
                        accept  = 1'b1;
                        state_d = ST_HELD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        digits_d      = digits_q;
        valid_next    = digit_valid_q;
        decode_err_d  = 1'b0;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;

        if (accept) begin
            if (g_legal) begin
                digits_d[{idx, 2'b00} +: 4] = g_nibble;
                valid_next[idx]             = 1'b1;
            end else if (g_blank) begin
                valid_next[idx] = 1'b0;
            end else begin
                decode_err_d = 1'b1;
            end
        end

        // Completion looks at post-capture validity so the completing digit is in the snapshot
        digit_valid_d = valid_next;
        if (((valid_next & digit_en) == digit_en) && (digit_en != '0)) begin
            frame_d       = digits_d;
            frame_valid_d = 1'b1;
            digit_valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg_q         <= '1;
            an_q          <= '1;
            seg_prev_q    <= '1;
            an_prev_q     <= '1;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            digits_q      <= '0;
            digit_valid_q <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            decode_err_q  <= 1'b0;
        end else begin
            seg_q         <= seg_d;
            an_q          <= an_d;
            seg_prev_q    <= seg_prev_d;
            an_prev_q     <= an_prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digits_q      <= digits_d;
            digit_valid_q <= digit_valid_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            decode_err_q  <= decode_err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = digit_valid_q;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign decode_err  = decode_err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: a vector table of single-digit captures
// plus hand-written sequences for scanning, debounce, reset and idle cases.
module tb_seg_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  segs;
    logic [3:0]  anodes;
    logic [3:0]  digit_en;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [15:0] frame;
    logic        frame_valid;
    logic        decode_err;

    int checks   = 0;
    int failures = 0;

    seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .segs        (segs),
        .anodes      (anodes),
        .digit_en    (digit_en),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame       (frame),
        .frame_valid (frame_valid),
        .decode_err  (decode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  sg;
        logic [3:0]  an;
        logic [3:0]  en;
        int          cycles;
        int          exp_fv;
        int          exp_err;
        int          exp_fv_tick;
        logic [15:0] exp_frame;
        logic [15:0] exp_digits;
        logic [3:0]  exp_dv;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        segs    = 7'b1111111;
        anodes  = 4'b1111;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Drive one pair for n cycles; report pulse counts and the tick of the first frame_valid
    task automatic present(input logic [3:0] an, input logic [6:0] sg, input logic [3:0] en,
                           input int n, output int fv_cnt, output int err_cnt, output int fv_tick);
        anodes   = an;
        segs     = sg;
        digit_en = en;
        fv_cnt   = 0;
        err_cnt  = 0;
        fv_tick  = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (frame_valid) begin
                fv_cnt++;
                if (fv_tick == 0) fv_tick = i;
            end
            if (decode_err) err_cnt++;
        end
    endtask

    function automatic vec_t mk(input logic [6:0] sg, input logic [3:0] en, input int fv,
                                input int err, input logic [15:0] fr, input logic [15:0] dg,
                                input logic [3:0] dv);
        vec_t v;
        v.sg = sg; v.an = 4'b1110; v.en = en; v.cycles = 9;
        v.exp_fv = fv; v.exp_err = err; v.exp_fv_tick = (fv > 0) ? 5 : 0;
        v.exp_frame = fr; v.exp_digits = dg; v.exp_dv = dv;
        return v;
    endfunction

    initial begin
        logic [6:0] glyph [16];
        int fv, err, ft, total_fv, total_err;

        glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010;
        glyph[3]  = 7'b0000110; glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
        glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111; glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0001100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000;
        glyph[15] = 7'b0111000;

        vecs.push_back(mk(glyph[10], 4'b0001, 1, 0, 16'h000A, 16'h000A, 4'b0000));
        for (int g = 0; g < 16; g++)
            if (g != 10)
                vecs.push_back(mk(glyph[g], 4'b0001, 1, 0, 16'(g), 16'(g), 4'b0000));
        vecs.push_back(mk(7'b1111111, 4'b0001, 0, 0, 16'h000F, 16'h000F, 4'b0000));
        vecs.push_back(mk(7'b1111110, 4'b0001, 0, 1, 16'h000F, 16'h000F, 4'b0000));
        vecs.push_back(mk(glyph[5],   4'b0001, 1, 0, 16'h0005, 16'h0005, 4'b0000));
        vecs.push_back(mk(glyph[3],   4'b0000, 0, 0, 16'h0005, 16'h0003, 4'b0001));

        digit_en = 4'b0001;
        reset_n  = 1'b0;
        segs     = 7'b0001000;
        anodes   = 4'b1110;
        tick();
        check("rst_digits", 32'(digits), 0);
        check("rst_dv", 32'(digit_valid), 0);
        check("rst_frame", 32'(frame), 0);
        check("rst_fv", 32'(frame_valid), 0);
        check("rst_err", 32'(decode_err), 0);
        do_reset();

        foreach (vecs[i]) begin
            present(vecs[i].an, vecs[i].sg, vecs[i].en, vecs[i].cycles, fv, err, ft);
            check($sformatf("vec%0d_fv_count", i), 32'(fv), 32'(vecs[i].exp_fv));
            check($sformatf("vec%0d_err_count", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_fv_tick", i), 32'(ft), 32'(vecs[i].exp_fv_tick));
            check($sformatf("vec%0d_frame", i), 32'(frame), 32'(vecs[i].exp_frame));
            check($sformatf("vec%0d_digits", i), 32'(digits), 32'(vecs[i].exp_digits));
            check($sformatf("vec%0d_dv", i), 32'(digit_valid), 32'(vecs[i].exp_dv));
        end

        // Enabling an already-valid digit completes a frame on the next edge
        present(4'b1110, glyph[3], 4'b0001, 3, fv, err, ft);
        check("en_late_fv_tick", 32'(ft), 1);
        check("en_late_fv_count", 32'(fv), 1);
        check("en_late_frame", 32'(frame), 32'h0003);

        do_reset();
        total_fv = 0;
        present(4'b0111, glyph[1], 4'b1111, 8, fv, err, ft); total_fv += fv;
        present(4'b1011, glyph[2], 4'b1111, 8, fv, err, ft); total_fv += fv;
        present(4'b1101, glyph[3], 4'b1111, 8, fv, err, ft); total_fv += fv;
        check("scan_dv_before_last", 32'(digit_valid), 32'b1110);
        present(4'b1110, glyph[4], 4'b1111, 8, fv, err, ft); total_fv += fv;
        check("scan_last_fv_tick", 32'(ft), 5);
        check("scan_total_fv", 32'(total_fv), 1);
        check("scan_frame", 32'(frame), 32'h1234);
        check("scan_dv_cleared", 32'(digit_valid), 0);

        // Reset mid-SETTLE with the same pair held throughout
        present(4'b1110, glyph[7], 4'b0001, 3, fv, err, ft);
        reset_n = 1'b0;
        tick();
        check("midrst_digits", 32'(digits), 0);
        check("midrst_frame", 32'(frame), 0);
        check("midrst_dv", 32'(digit_valid), 0);
        check("midrst_fv", 32'(frame_valid), 0);
        reset_n = 1'b1;
        ft = 0;
        for (int i = 1; i <= 20 && ft == 0; i++) begin
            tick();
            if (frame_valid) ft = i;
        end
        check("midrst_latency", 32'(ft), 5);
        check("midrst_frame_after", 32'(frame), 32'h0007);

        do_reset();
        digit_en = 4'b0001;
        anodes   = 4'b1101;
        total_fv = 0;
        total_err = 0;
        for (int i = 0; i < 24; i++) begin
            segs = (i % 6 < 3) ? glyph[1] : glyph[2];
            tick();
            if (frame_valid) total_fv++;
            if (decode_err) total_err++;
            if (digit_valid != 4'b0000) total_fv += 100;
        end
        check("toggle_no_capture", 32'(total_fv), 0);
        check("toggle_no_err", 32'(total_err), 0);
        check("toggle_digits", 32'(digits), 0);

        present(4'b1011, 7'b1111110, 4'b0001, 10, fv, err, ft);
        check("illegal_err_count", 32'(err), 1);
        check("illegal_fv_count", 32'(fv), 0);
        check("illegal_digits", 32'(digits), 0);
        check("illegal_dv", 32'(digit_valid), 0);

        do_reset();
        present(4'b0000, glyph[8], 4'b0001, 20, fv, err, ft);
        total_fv = fv; total_err = err;
        present(4'b1100, glyph[8], 4'b0001, 20, fv, err, ft);
        total_fv += fv; total_err += err;
        check("multi_an_fv", 32'(total_fv), 0);
        check("multi_an_err", 32'(total_err), 0);
        check("multi_an_digits", 32'(digits), 0);
        check("multi_an_dv", 32'(digit_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
